theta_apply: RTL

THETA_APPLY -- requirements
Module: theta_apply

---
 rtl/theta_apply.sv | 139 +++++++++++++
 1 files changed

// File: rtl/theta_apply.sv
// Streaming theta step over a 64-slice state: one 25-bit slice per cycle in,
// theta-applied slices out in order z=1..63 then 0 (slice 0 needs C_63).
module theta_apply #(
  parameter int N      = 25,
  parameter int SLICES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [N-1:0] in_slice,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_slice,
  output logic [5:0]   out_z,
  input  logic         out_ready,
  output logic         done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FIRST  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_LAST   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [5:0] Z_LAST = 6'(SLICES - 1);

  logic [2:0]   state;
  logic [5:0]   z_cnt;
  logic [N-1:0] slice0;
  logic [4:0]   c0;
  logic [4:0]   c_prev;
  logic [4:0]   c63;
  logic [4:0]   c_in;
  logic         in_xfer;
  logic         out_xfer;

  function automatic logic [4:0] col_parity(input logic [N-1:0] s);
    logic [4:0] c;
    c = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        c[x] = c[x] ^ s[5*y+x];
    return c;
  endfunction

  function automatic logic [N-1:0] theta(input logic [N-1:0] s,
                                         input logic [4:0]   c_cur,
                                         input logic [4:0]   c_prv);
    logic [4:0]   d;
    logic [N-1:0] r;
    r = s;
    for (int x = 0; x < 5; x++)
      d[x] = c_cur[(x+4)%5] ^ c_prv[(x+1)%5];
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[5*y+x] = s[5*y+x] ^ d[x];
    return r;
  endfunction

  assign c_in     = col_parity(in_slice);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_FIRST:  in_ready = 1'b1;
      S_STREAM: in_ready = !out_valid || out_ready;
      default:  in_ready = 1'b0;
    endcase
  end

  // Single output register stage; input acceptance is gated on it being free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      z_cnt     <= '0;
      slice0    <= '0;
      c0        <= '0;
      c_prev    <= '0;
      c63       <= '0;
      out_valid <= 1'b0;
      out_slice <= '0;
      out_z     <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_FIRST;
        end
        S_FIRST: begin
          if (in_xfer) begin
            slice0 <= in_slice;
            c0     <= c_in;
            c_prev <= c_in;
            z_cnt  <= 6'd1;
            state  <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (in_xfer) begin
            out_slice <= theta(in_slice, c_in, c_prev);
            out_z     <= z_cnt;
            out_valid <= 1'b1;
            c_prev    <= c_in;
            z_cnt     <= z_cnt + 6'd1;
            if (z_cnt == Z_LAST) begin
              c63   <= c_in;
              state <= S_LAST;
            end
          end else if (out_xfer) begin
            out_valid <= 1'b0;
          end
        end
        S_LAST: begin
          // out_z==0 marks the deferred slice-0 result already being presented
          if (out_valid && out_z == 6'd0) begin
            if (out_ready) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end else if (!out_valid || out_ready) begin
            out_slice <= theta(slice0, c0, c63);
            out_z     <= 6'd0;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
